// File: rtl/tl_occ_cnt_pkg.sv
// Shared width helpers and per-channel status payload for the TL occupancy counter.
package tl_occ_cnt_pkg;

    function automatic int unsigned cnt_w_f(input int unsigned depth);
        return depth + 1;
    endfunction

    function automatic int unsigned beat_w_f(input int unsigned max_beats);
        return $clog2(max_beats + 1);
    endfunction

    typedef struct packed {
        logic full;
        logic empty;
        logic afull;
        logic aempty;
        logic ovf;
        logic udf;
    } ch_status_t;

endpackage

// File: rtl/tl_occ_cnt_ch.sv
// One channel: saturating multi-beat occupancy counter with sticky errors,
// high-watermark and threshold flags.
module tl_occ_cnt_ch
    import tl_occ_cnt_pkg::*;
#(
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned MAX_BEATS = 2,
    localparam int unsigned CNT_W    = cnt_w_f(DEPTH),
    localparam int unsigned BEAT_W   = beat_w_f(MAX_BEATS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [BEAT_W-1:0] inc_i,
    input  logic [BEAT_W-1:0] dec_i,
    input  logic [CNT_W-1:0]  afull_th_i,
    input  logic [CNT_W-1:0]  aempty_th_i,
    input  logic              err_clr_i,
    input  logic              wm_clr_i,
    output logic [CNT_W-1:0]  cnt_o,
    output logic [CNT_W-1:0]  wm_o,
    output ch_status_t        status_o
);

    localparam int unsigned SW  = CNT_W + 2;
    localparam int unsigned CAP = 2 ** DEPTH;
    localparam logic [CNT_W-1:0]     CAP_C = CNT_W'(CAP);
    localparam logic signed [SW-1:0] CAP_S = SW'(CAP);

    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [CNT_W-1:0]     wm_q, wm_d;
    logic                 ovf_q, ovf_d;
    logic                 udf_q, udf_d;
    logic signed [SW-1:0] nxt_s;
    logic                 ovf_set;
    logic                 udf_set;

    // Two guard bits keep cnt+inc-dec exact so neither direction can wrap.
    always_comb begin
        nxt_s   = SW'(cnt_q) + SW'(inc_i) - SW'(dec_i);
        cnt_d   = CNT_W'(nxt_s);
        ovf_set = 1'b0;
        udf_set = 1'b0;
        if (nxt_s > CAP_S) begin
            cnt_d   = CAP_C;
            ovf_set = 1'b1;
        end else if (nxt_s < 0) begin
            cnt_d   = '0;
            udf_set = 1'b1;
        end

        ovf_d = ovf_set | (ovf_q & ~err_clr_i);
        udf_d = udf_set | (udf_q & ~err_clr_i);

        if (wm_clr_i || (cnt_d > wm_q)) begin
            wm_d = cnt_d;
        end else begin
            wm_d = wm_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            wm_q  <= '0;
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            wm_q  <= wm_d;
            ovf_q <= ovf_d;
            udf_q <= udf_d;
        end
    end

    assign cnt_o           = cnt_q;
    assign wm_o            = wm_q;
    assign status_o.full   = (cnt_q == CAP_C);
    assign status_o.empty  = (cnt_q == '0);
    assign status_o.afull  = (cnt_q >= afull_th_i);
    assign status_o.aempty = (cnt_q <= aempty_th_i);
    assign status_o.ovf    = ovf_q;
    assign status_o.udf    = udf_q;

endmodule

// File: rtl/tl_occ_cnt.sv
// Multi-channel TL FIFO occupancy counter: NUM_CH independent channel
// instances with packed per-channel buses.
module tl_occ_cnt
    import tl_occ_cnt_pkg::*;
#(
    parameter int unsigned NUM_CH    = 4,
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned MAX_BEATS = 2,
    localparam int unsigned CNT_W    = cnt_w_f(DEPTH),
    localparam int unsigned BEAT_W   = beat_w_f(MAX_BEATS)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_CH*BEAT_W-1:0] inc_i,
    input  logic [NUM_CH*BEAT_W-1:0] dec_i,
    input  logic [CNT_W-1:0]         afull_th_i,
    input  logic [CNT_W-1:0]         aempty_th_i,
    input  logic [NUM_CH-1:0]        err_clr_i,
    input  logic [NUM_CH-1:0]        wm_clr_i,
    output logic [NUM_CH*CNT_W-1:0]  cnt_o,
    output logic [NUM_CH*CNT_W-1:0]  wm_o,
    output logic [NUM_CH-1:0]        full_o,
    output logic [NUM_CH-1:0]        empty_o,
    output logic [NUM_CH-1:0]        afull_o,
    output logic [NUM_CH-1:0]        aempty_o,
    output logic [NUM_CH-1:0]        ovf_o,
    output logic [NUM_CH-1:0]        udf_o
);

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        ch_status_t st;

        tl_occ_cnt_ch #(
            .DEPTH     (DEPTH),
            .MAX_BEATS (MAX_BEATS)
        ) u_ch (
            .clk         (clk),
            .rst         (rst),
            .inc_i       (inc_i[c*BEAT_W +: BEAT_W]),
            .dec_i       (dec_i[c*BEAT_W +: BEAT_W]),
            .afull_th_i  (afull_th_i),
            .aempty_th_i (aempty_th_i),
            .err_clr_i   (err_clr_i[c]),
            .wm_clr_i    (wm_clr_i[c]),
            .cnt_o       (cnt_o[c*CNT_W +: CNT_W]),
            .wm_o        (wm_o[c*CNT_W +: CNT_W]),
            .status_o    (st)
        );

        assign full_o[c]   = st.full;
        assign empty_o[c]  = st.empty;
        assign afull_o[c]  = st.afull;
        assign aempty_o[c] = st.aempty;
        assign ovf_o[c]    = st.ovf;
        assign udf_o[c]    = st.udf;
    end

endmodule
